// File: rtl/bus_interface_unit_pkg.sv
// bus_interface_unit_pkg
// Shared definitions for the 6502 external bus interface: FSM state
// encodings, bus phase codes and default flag bit positions. The phase
// codes are also used by instruction_decode.
package bus_interface_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADH  = 2'd1,
    ST_ADL  = 2'd2,
    ST_DATA = 2'd3
  } bus_state_t;

  localparam logic [1:0] PH_IDLE = 2'b00;
  localparam logic [1:0] PH_ADH  = 2'b01;
  localparam logic [1:0] PH_ADL  = 2'b10;
  localparam logic [1:0] PH_DATA = 2'b11;

  localparam int DEF_FLAG_RW_BIT   = 0;
  localparam int DEF_FLAG_SYNC_BIT = 1;

endpackage

// File: rtl/bus_wait_timer.sv
// bus_wait_timer
// Saturating up-counter used to bound the read DATA-phase wait.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear (takes priority over en)
//   en         : count one wait cycle
//   expired    : high when the current enabled tick brings the count to MAX
// MAX = 0 disables the timer: expired never asserts.
module bus_wait_timer #(
  parameter int MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = (MAX > 0) ? $clog2(MAX + 1) : 1;
  localparam logic [W-1:0] TOP  = (MAX > 0) ? W'(MAX) : '0;
  localparam logic [W-1:0] LAST = (MAX > 0) ? W'(MAX - 1) : '0;

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != TOP)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (MAX > 0) && en && (count == LAST);

endmodule

// File: rtl/bus_interface_unit.sv
// bus_interface_unit
// Turns one core memory request into a three-phase external bus cycle
// (ADH, ADL, DATA) on uo_out / uio_*. Reads wait on ext_rdy with a timeout.
// Ports:
//   clk, rst_n                      : clock, async active-low reset
//   req, addr, we, wdata, sync      : core request (sampled when req_ready)
//   req_ready                       : high in IDLE
//   rdata, done, err                : read data and completion pulses
//   ext_rdy, uio_in                 : external ready and data in
//   uo_out, uio_out, uio_oe, phase  : registered bus pins
//
// state | meaning
// IDLE  | waiting for req; outputs parked at 0
// ADH   | uo_out carries addr[15:8]
// ADL   | uo_out carries addr[7:0]
// DATA  | uo_out carries RW/SYNC; write drives uio, read waits for ext_rdy
module bus_interface_unit
  import bus_interface_unit_pkg::*;
#(
  parameter int WAIT_MAX      = 15,
  parameter int FLAG_RW_BIT   = DEF_FLAG_RW_BIT,
  parameter int FLAG_SYNC_BIT = DEF_FLAG_SYNC_BIT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  output logic        req_ready,
  input  logic [15:0] addr,
  input  logic        we,
  input  logic [7:0]  wdata,
  input  logic        sync,
  output logic [7:0]  rdata,
  output logic        done,
  output logic        err,
  input  logic        ext_rdy,
  output logic [7:0]  uo_out,
  input  logic [7:0]  uio_in,
  output logic [7:0]  uio_out,
  output logic [7:0]  uio_oe,
  output logic [1:0]  phase
);

  bus_state_t  state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        sync_q, sync_d;
  logic [7:0]  uo_d, uio_out_d, uio_oe_d, rdata_d;
  logic [1:0]  phase_d;
  logic        done_d, err_d;
  logic        accept, wait_en, expired;

  assign req_ready = (state_q == ST_IDLE);
  assign accept    = req_ready && req;
  assign wait_en   = (state_q == ST_DATA) && !we_q && !ext_rdy;

  bus_wait_timer #(.MAX(WAIT_MAX)) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (accept),
    .en      (wait_en),
    .expired (expired)
  );

  function automatic logic [7:0] flag_byte(input logic rw, input logic sy);
    logic [7:0] f;
    f = 8'h00;
    f[FLAG_RW_BIT]   = rw;
    f[FLAG_SYNC_BIT] = sy;
    return f;
  endfunction

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    sync_d    = sync_q;
    uo_d      = uo_out;
    uio_out_d = uio_out;
    uio_oe_d  = uio_oe;
    phase_d   = phase;
    rdata_d   = rdata;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        uo_d      = 8'h00;
        uio_out_d = 8'h00;
        uio_oe_d  = 8'h00;
        phase_d   = PH_IDLE;
        if (req) begin
          addr_d  = addr;
          we_d    = we;
          wdata_d = wdata;
          sync_d  = sync;
          uo_d    = addr[15:8];
          phase_d = PH_ADH;
          state_d = ST_ADH;
        end
      end
      ST_ADH: begin
        uo_d    = addr_q[7:0];
        phase_d = PH_ADL;
        state_d = ST_ADL;
      end
      ST_ADL: begin
        uo_d    = flag_byte(!we_q, sync_q);
        phase_d = PH_DATA;
        state_d = ST_DATA;
        if (we_q) begin
          uio_out_d = wdata_q;
          uio_oe_d  = 8'hFF;
        end else begin
          uio_oe_d  = 8'h00;
        end
      end
      ST_DATA: begin
        // Ready wins over an expiry landing on the same edge.
        if (we_q || ext_rdy || expired) begin
          state_d   = ST_IDLE;
          uo_d      = 8'h00;
          uio_out_d = 8'h00;
          uio_oe_d  = 8'h00;
          phase_d   = PH_IDLE;
          done_d    = 1'b1;
          if (!we_q && ext_rdy) begin
            rdata_d = uio_in;
          end else if (!we_q) begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      sync_q  <= 1'b0;
      uo_out  <= '0;
      uio_out <= '0;
      uio_oe  <= '0;
      phase   <= PH_IDLE;
      rdata   <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      sync_q  <= sync_d;
      uo_out  <= uo_d;
      uio_out <= uio_out_d;
      uio_oe  <= uio_oe_d;
      phase   <= phase_d;
      rdata   <= rdata_d;
      done    <= done_d;
      err     <= err_d;
    end
  end

endmodule

// File: tb/tb_bus_interface_unit.sv
// Testbench for bus_interface_unit (WAIT_MAX = 3).
module tb_bus_interface_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        req_ready;
  logic [15:0] addr;
  logic        we;
  logic [7:0]  wdata;
  logic        sync;
  logic [7:0]  rdata;
  logic        done;
  logic        err;
  logic        ext_rdy;
  logic [7:0]  uo_out;
  logic [7:0]  uio_in;
  logic [7:0]  uio_out;
  logic [7:0]  uio_oe;
  logic [1:0]  phase;

  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;

  always #5 clk = ~clk;

  bus_interface_unit #(.WAIT_MAX(3), .FLAG_RW_BIT(0), .FLAG_SYNC_BIT(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_ready (req_ready),
    .addr      (addr),
    .we        (we),
    .wdata     (wdata),
    .sync      (sync),
    .rdata     (rdata),
    .done      (done),
    .err       (err),
    .ext_rdy   (ext_rdy),
    .uo_out    (uo_out),
    .uio_in    (uio_in),
    .uio_out   (uio_out),
    .uio_oe    (uio_oe),
    .phase     (phase)
  );

  typedef struct {
    logic        req;
    logic [15:0] addr;
    logic        we;
    logic [7:0]  wdata;
    logic        sync;
    logic        rdy;
    logic [7:0]  uin;
    logic [7:0]  e_uo;
    logic [7:0]  e_uout;
    logic [7:0]  e_oe;
    logic [1:0]  e_ph;
    logic        e_done;
    logic        e_err;
    logic [7:0]  e_rdata;
    logic        e_ready;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (done === 1'b1) n_done++;
  endtask

  task automatic check_outs(input string tag, input logic [7:0] e_uo, input logic [7:0] e_uout,
                            input logic [7:0] e_oe, input logic [1:0] e_ph, input logic e_done,
                            input logic e_err, input logic [7:0] e_rdata, input logic e_ready);
    check({tag, " uo_out"},    16'(uo_out),    16'(e_uo));
    check({tag, " uio_out"},   16'(uio_out),   16'(e_uout));
    check({tag, " uio_oe"},    16'(uio_oe),    16'(e_oe));
    check({tag, " phase"},     16'(phase),     16'(e_ph));
    check({tag, " done"},      16'(done),      16'(e_done));
    check({tag, " err"},       16'(err),       16'(e_err));
    check({tag, " rdata"},     16'(rdata),     16'(e_rdata));
    check({tag, " req_ready"}, 16'(req_ready), 16'(e_ready));
  endtask

  initial begin
    // req addr we wdata sync rdy uin | uo uio_out oe ph done err rdata ready
    // read ABCD, no wait
    vecs[0]  = '{1'b1, 16'hABCD, 1'b0, 8'h00, 1'b0, 1'b1, 8'h5A, 8'hAB, 8'h00, 8'h00, 2'd1, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[1]  = '{1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 8'h5A, 8'hCD, 8'h00, 8'h00, 2'd2, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[2]  = '{1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 8'h5A, 8'h01, 8'h00, 8'h00, 2'd3, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[3]  = '{1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 8'h5A, 8'h00, 8'h00, 8'h00, 2'd0, 1'b1, 1'b0, 8'h5A, 1'b1};
    // write 0200 <- C3, accepted back-to-back in the done cycle; ext_rdy ignored
    vecs[4]  = '{1'b1, 16'h0200, 1'b1, 8'hC3, 1'b0, 1'b0, 8'h00, 8'h02, 8'h00, 8'h00, 2'd1, 1'b0, 1'b0, 8'h5A, 1'b0};
    vecs[5]  = '{1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 2'd2, 1'b0, 1'b0, 8'h5A, 1'b0};
    vecs[6]  = '{1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'hC3, 8'hFF, 2'd3, 1'b0, 1'b0, 8'h5A, 1'b0};
    vecs[7]  = '{1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 1'b1, 1'b0, 8'h5A, 1'b1};
    // read 4000 timeout: ext_rdy stuck low, 3 wait cycles
    vecs[8]  = '{1'b1, 16'h4000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h99, 8'h40, 8'h00, 8'h00, 2'd1, 1'b0, 1'b0, 8'h5A, 1'b0};
    vecs[9]  = '{1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h99, 8'h00, 8'h00, 8'h00, 2'd2, 1'b0, 1'b0, 8'h5A, 1'b0};
    vecs[10] = '{1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h99, 8'h01, 8'h00, 8'h00, 2'd3, 1'b0, 1'b0, 8'h5A, 1'b0};
    vecs[11] = '{1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h99, 8'h01, 8'h00, 8'h00, 2'd3, 1'b0, 1'b0, 8'h5A, 1'b0};
    vecs[12] = '{1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h99, 8'h01, 8'h00, 8'h00, 2'd3, 1'b0, 1'b0, 8'h5A, 1'b0};
    vecs[13] = '{1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h99, 8'h00, 8'h00, 8'h00, 2'd0, 1'b1, 1'b1, 8'h5A, 1'b1};
    // read 1234 with 2 wait cycles (counter must have been cleared on accept)
    vecs[14] = '{1'b1, 16'h1234, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h12, 8'h00, 8'h00, 2'd1, 1'b0, 1'b0, 8'h5A, 1'b0};
    vecs[15] = '{1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h34, 8'h00, 8'h00, 2'd2, 1'b0, 1'b0, 8'h5A, 1'b0};
    vecs[16] = '{1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h01, 8'h00, 8'h00, 2'd3, 1'b0, 1'b0, 8'h5A, 1'b0};
    vecs[17] = '{1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h01, 8'h00, 8'h00, 2'd3, 1'b0, 1'b0, 8'h5A, 1'b0};
    vecs[18] = '{1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h01, 8'h00, 8'h00, 2'd3, 1'b0, 1'b0, 8'h5A, 1'b0};
    vecs[19] = '{1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 8'h77, 8'h00, 8'h00, 8'h00, 2'd0, 1'b1, 1'b0, 8'h77, 1'b1};

    rst_n = 1'b0; req = 1'b0; addr = '0; we = 1'b0; wdata = '0; sync = 1'b0;
    ext_rdy = 1'b0; uio_in = '0;
    #22;
    check_outs("reset", 8'h00, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 8'h00, 1'b1);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 20; i++) begin
      req = vecs[i].req; addr = vecs[i].addr; we = vecs[i].we; wdata = vecs[i].wdata;
      sync = vecs[i].sync; ext_rdy = vecs[i].rdy; uio_in = vecs[i].uin;
      step();
      check_outs($sformatf("v%0d", i), vecs[i].e_uo, vecs[i].e_uout, vecs[i].e_oe, vecs[i].e_ph,
                 vecs[i].e_done, vecs[i].e_err, vecs[i].e_rdata, vecs[i].e_ready);
    end

    // SYNC fetch with a stray req during ADL
    req = 1'b0; ext_rdy = 1'b0;
    step();
    n_done = 0;
    req = 1'b1; addr = 16'h00FE; we = 1'b0; sync = 1'b1;
    step();
    check("sync ADH uo_out", 16'(uo_out), 16'h0000);
    req = 1'b0; addr = 16'h0000; sync = 1'b0;
    step();
    check("sync ADL uo_out", 16'(uo_out), 16'h00FE);
    check("sync ADL req_ready", 16'(req_ready), 16'h0000);
    req = 1'b1; addr = 16'hFFFF; we = 1'b1;
    step();
    check("sync DATA uo_out", 16'(uo_out), 16'h0003);
    check("sync DATA uio_oe", 16'(uio_oe), 16'h0000);
    check("sync DATA req_ready", 16'(req_ready), 16'h0000);
    req = 1'b0; we = 1'b0; ext_rdy = 1'b1; uio_in = 8'h11;
    step();
    check("sync done", 16'(done), 16'h0001);
    check("sync rdata", 16'(rdata), 16'h0011);
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("sync idle%0d phase", k), 16'(phase), 16'h0000);
    end
    check("sync done count", 16'(n_done), 16'h0001);

    // Reset asserted during DATA of a write
    req = 1'b1; addr = 16'h0300; we = 1'b1; wdata = 8'hAA;
    step();
    req = 1'b0;
    step();
    step();
    check("rstw DATA uio_oe", 16'(uio_oe), 16'h00FF);
    check("rstw DATA uio_out", 16'(uio_out), 16'h00AA);
    n_done = 0;
    #2 rst_n = 1'b0;
    #1;
    check_outs("rstw async", 8'h00, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 8'h00, 1'b1);
    step();
    step();
    check_outs("rstw held", 8'h00, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 8'h00, 1'b1);
    #3 rst_n = 1'b1;
    check("rstw no done", 16'(n_done), 16'h0000);
    req = 1'b1; addr = 16'h8001; we = 1'b0; ext_rdy = 1'b1; uio_in = 8'h3C;
    step();
    check("post ADH uo_out", 16'(uo_out), 16'h0080);
    req = 1'b0;
    step();
    check("post ADL uo_out", 16'(uo_out), 16'h0001);
    step();
    check("post DATA phase", 16'(phase), 16'h0003);
    step();
    check_outs("post done", 8'h00, 8'h00, 8'h00, 2'd0, 1'b1, 1'b0, 8'h3C, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
